// File: rtl/iv_pkg.sv
// Shared types and constants for the melody sequencer: note codes, ROM entry
// layout, FSM states and the default melody ROM.
package iv_pkg;

  localparam int unsigned NOTE_W    = 2;
  localparam int unsigned DUR_W     = 3;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned ROM_DEPTH = 8;

  localparam logic [NOTE_W-1:0] NOTE_FS5 = 2'd0;
  localparam logic [NOTE_W-1:0] NOTE_A5  = 2'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS6 = 2'd2;
  localparam logic [NOTE_W-1:0] NOTE_E6  = 2'd3;

  // Entry lasts dur+1 beats; a rest mutes the gate and keeps the previous note.
  typedef struct packed {
    logic              rest;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } seq_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

  localparam seq_entry_t SEQ_ROM [ROM_DEPTH] = '{
    '{rest: 1'b0, note: NOTE_FS5, dur: 3'd1},
    '{rest: 1'b0, note: NOTE_A5,  dur: 3'd1},
    '{rest: 1'b0, note: NOTE_CS6, dur: 3'd1},
    '{rest: 1'b0, note: NOTE_E6,  dur: 3'd3},
    '{rest: 1'b1, note: NOTE_E6,  dur: 3'd0},
    '{rest: 1'b0, note: NOTE_E6,  dur: 3'd0},
    '{rest: 1'b0, note: NOTE_CS6, dur: 3'd0},
    '{rest: 1'b0, note: NOTE_A5,  dur: 3'd3}
  };

endpackage

// File: rtl/note_sequencer_seq_rom.sv
// Combinational melody ROM lookup; swap SEQ_ROM contents without touching the sequencer.
module seq_rom
  import iv_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output seq_entry_t       entry_c
);

  assign entry_c = SEQ_ROM[idx];

endmodule

// File: rtl/note_sequencer.sv
// Tempo-driven melody controller: steps the note ROM and drives the oscillator
// note select and gate. Define NOTE_SEQ_ARTIC_GAP_EN to mute the tail of each entry.
module note_sequencer
  import iv_pkg::*;
#(
  parameter int unsigned TICKS_PER_BEAT = 5_000_000,
  parameter int unsigned GAP_TICKS      = 500_000
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              STOP,
  input  logic              LOOP,
  output logic [NOTE_W-1:0] NOTE_SEL,
  output logic              GATE,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned      TICK_W    = $clog2(TICKS_PER_BEAT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [TICK_W-1:0] GAP_START = TICK_W'(TICKS_PER_BEAT - GAP_TICKS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(ROM_DEPTH - 1);
`ifdef NOTE_SEQ_ARTIC_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [DUR_W-1:0]  beats_q, beats_d;
  logic [NOTE_W-1:0] note_sel_q, note_sel_d;
  logic              gate_q, gate_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IDX_W-1:0]  rom_addr_c;
  seq_entry_t        rom_entry_c;

  // In PLAY the ROM always looks one entry ahead (7 wraps to 0); from IDLE it reads entry 0.
  assign rom_addr_c = (state_q == PLAY) ? IDX_W'(idx_q + IDX_W'(1)) : '0;

  seq_rom u_seq_rom (
    .idx     (rom_addr_c),
    .entry_c (rom_entry_c)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tick_d     = tick_q;
    beats_d    = beats_q;
    note_sel_d = note_sel_q;
    gate_d     = gate_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q == IDLE) begin
      if (START && !STOP) begin
        state_d = PLAY;
        busy_d  = 1'b1;
        idx_d   = '0;
        tick_d  = '0;
        beats_d = rom_entry_c.dur;
        gate_d  = !rom_entry_c.rest;
        if (!rom_entry_c.rest) note_sel_d = rom_entry_c.note;
      end
    end else begin
      if (STOP) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        gate_d  = 1'b0;
        idx_d   = '0;
        tick_d  = '0;
        beats_d = '0;
      end else if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (beats_q != '0) begin
          beats_d = beats_q - DUR_W'(1);
        end else if (idx_q != IDX_LAST || LOOP) begin
          idx_d   = rom_addr_c;
          beats_d = rom_entry_c.dur;
          gate_d  = !rom_entry_c.rest;
          if (!rom_entry_c.rest) note_sel_d = rom_entry_c.note;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          gate_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = '0;
          beats_d = '0;
        end
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end

    // Articulation gap: mute the tail of the final beat so repeated notes re-attack.
    if (GAP_EN && state_d == PLAY && beats_d == '0 && tick_d >= GAP_START) begin
      gate_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tick_q     <= '0;
      beats_q    <= '0;
      note_sel_q <= '0;
      gate_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      beats_q    <= beats_d;
      note_sel_q <= note_sel_d;
      gate_q     <= gate_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign NOTE_SEL = note_sel_q;
  assign GATE     = gate_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Randomized self-checking bench for note_sequencer against a timeline model of the melody.
module tb_note_sequencer;

  localparam int TPB = 4;
  localparam int GAP = 1;
`ifdef NOTE_SEQ_ARTIC_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START, STOP, LOOP;
  logic [1:0] NOTE_SEL;
  logic       GATE, BUSY, DONE;

  int n_checks = 0;
  int n_errors = 0;

  // Melody as written in the score: note code, rest flag, extra beats.
  int rom_note [8] = '{0, 1, 2, 3, 3, 3, 2, 1};
  int rom_rest [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int rom_dur  [8] = '{1, 1, 1, 3, 0, 0, 0, 3};

  bit m_play;
  int m_pos;
  int m_note;
  bit m_done;

  note_sequencer #(.TICKS_PER_BEAT(TPB), .GAP_TICKS(GAP)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .STOP     (STOP),
    .LOOP     (LOOP),
    .NOTE_SEL (NOTE_SEL),
    .GATE     (GATE),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int entry_len(input int i);
    return (rom_dur[i] + 1) * TPB;
  endfunction

  function automatic int seq_len();
    int s = 0;
    for (int i = 0; i < 8; i++) s += entry_len(i);
    return s;
  endfunction

  // Map a cycle offset within the melody to the entry playing and the offset inside it.
  function automatic void locate(input int pos, output int idx, output int off);
    int acc = 0;
    idx = 7;
    off = 0;
    for (int i = 0; i < 8; i++) begin
      if (pos < acc + entry_len(i)) begin
        idx = i;
        off = pos - acc;
        return;
      end
      acc += entry_len(i);
    end
  endfunction

  function automatic bit exp_gate();
    int idx, off;
    if (!m_play) return 1'b0;
    locate(m_pos, idx, off);
    if (rom_rest[idx] != 0) return 1'b0;
    if (GAP_ON && off >= entry_len(idx) - GAP) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_play = 1'b0;
    m_pos  = 0;
    m_note = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit lp);
    int idx, off;
    m_done = 1'b0;
    if (!m_play) begin
      if (st && !sp) begin
        m_play = 1'b1;
        m_pos  = 0;
      end
    end else if (sp) begin
      m_play = 1'b0;
    end else if (m_pos == seq_len() - 1) begin
      if (lp) m_pos = 0;
      else begin
        m_play = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_pos++;
    end
    if (m_play) begin
      locate(m_pos, idx, off);
      if (rom_rest[idx] == 0) m_note = rom_note[idx];
    end
  endtask

  task automatic compare_all();
    check("note_sel", 32'(NOTE_SEL), 32'(m_note));
    check("gate", 32'(GATE), 32'(exp_gate()));
    check("busy", 32'(BUSY), 32'(m_play));
    check("done", 32'(DONE), 32'(m_done));
  endtask

  // One clock: inputs set just after an edge, model stepped at the edge, outputs sampled 1 ns later.
  task automatic cyc(input bit st, input bit sp, input bit lp);
    START = st;
    STOP  = sp;
    LOOP  = lp;
    @(posedge CLK);
    model_step(st, sp, lp);
    #1;
    compare_all();
  endtask

  task automatic run_until_done(input string tag, input bit lp);
    int cnt = 0;
    while (!DONE && cnt < 400) begin
      cyc(1'b0, 1'b0, lp);
      cnt++;
    end
    check(tag, 32'(cnt), 32'(seq_len()));
  endtask

  initial begin
    RST_N = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    LOOP  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all();
    RST_N = 1'b1;

    // Idle with stray STOP/LOOP activity.
    for (int i = 0; i < 20; i++) cyc(1'b0, ($urandom % 4) == 0, 1'(($urandom % 2)));

    // Single non-looped pass, measuring first-BUSY to DONE.
    cyc(1'b1, 1'b0, 1'b0);
    run_until_done("seq_len_noloop", 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);

    // Looped playback, then release LOOP and expect one more full pass.
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2 * seq_len() + 3; i++) cyc(1'b0, 1'b0, 1'b1);
    while (m_pos != 0) cyc(1'b0, 1'b0, 1'b1);
    run_until_done("seq_len_after_loop", 1'b0);

    // STOP mid-note, then START together with STOP while idle.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (9) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);

    // Repeated START during playback must not disturb timing.
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < seq_len() + 5; i++) cyc(($urandom % 3) == 0 && m_pos < seq_len() - 2, 1'b0, 1'b0);

    // Random mix of START/STOP/LOOP.
    for (int i = 0; i < 800; i++)
      cyc(($urandom % 12) == 0, ($urandom % 90) == 0, ($urandom % 3) != 0);

    // Asynchronous reset mid-note.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (13 + ($urandom % 20)) cyc(1'b0, 1'b0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge CLK);
    #1;
    compare_all();
    RST_N = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    run_until_done("seq_len_after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
